// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- shares the single data-memory port between the core (port 0)
// and a second bus master (port 1).
//
// A registered owner drives the one dmem port. Ties go round-robin (the port
// that was not granted last wins). A port may hold ownership with `lock`.
// Port 0 gets a stall flag so the core can freeze its PC while it waits.
//
// Optional feature macro: DMEM_ARB_STARVE_EN
//   When defined, a port that keeps a lock for MAX_LOCK cycles while the other
//   port waits is forced off the bus. When undefined, locks are honoured
//   indefinitely and the lock counter does not exist.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   pX_req/lock/we/addr/wd     port X request, lock, write enable, address, write data
//   pX_gnt, pX_rd              port X owns memory this cycle, read data (0 if not granted)
//   p0_stall                   port 0 requesting but not granted
//   owner                      0 = none, 1 = port 0, 2 = port 1
//   mem_addr/wd/we, mem_rd     dmem port (mem_rd is a combinational read)
module dmem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p0_req,
  input  logic             p1_req,
  input  logic             p0_lock,
  input  logic             p1_lock,
  input  logic             p0_we,
  input  logic             p1_we,
  input  logic [WIDTH-1:0] p0_addr,
  input  logic [WIDTH-1:0] p1_addr,
  input  logic [WIDTH-1:0] p0_wd,
  input  logic [WIDTH-1:0] p1_wd,
  output logic             p0_gnt,
  output logic             p1_gnt,
  output logic [WIDTH-1:0] p0_rd,
  output logic [WIDTH-1:0] p1_rd,
  output logic             p0_stall,
  output logic [1:0]       owner,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } own_e;

  if (MAX_LOCK < 1 || MAX_LOCK > 255) begin : g_bad_max_lock
    $error("dmem_arbiter: MAX_LOCK must be in 1..255");
  end

  own_e owner_q, owner_d;
  logic last_q;          // 1: port 1 was granted last, 0: port 0
  logic own_req, own_lock, oth_req;
  own_e oth;
  logic hold;            // current owner asks to keep the bus
  logic force_sw;        // starvation guard overrides the lock

  // Owner-relative view of the two ports.
  always_comb begin
    own_req  = 1'b0;
    own_lock = 1'b0;
    oth_req  = 1'b0;
    oth      = OWN_NONE;
    case (owner_q)
      OWN_P0: begin
        own_req  = p0_req;
        own_lock = p0_lock;
        oth_req  = p1_req;
        oth      = OWN_P1;
      end
      OWN_P1: begin
        own_req  = p1_req;
        own_lock = p1_lock;
        oth_req  = p0_req;
        oth      = OWN_P0;
      end
      default: ;
    endcase
  end

  assign hold = own_req & own_lock;

`ifdef DMEM_ARB_STARVE_EN
  logic [7:0] lock_cnt;

  assign force_sw = hold & oth_req & (lock_cnt >= 8'(MAX_LOCK));

  // Counts cycles kept by lock while the other port waits. Any other outcome
  // (owner change, forced switch, idle competitor) clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      lock_cnt <= 8'd0;
    else if (hold && !force_sw && oth_req)
      lock_cnt <= (lock_cnt == 8'hFF) ? lock_cnt : lock_cnt + 8'd1;
    else
      lock_cnt <= 8'd0;
  end
`else
  assign force_sw = 1'b0;
`endif

  always_comb begin
    owner_d = OWN_NONE;
    if (hold && !force_sw)
      owner_d = owner_q;
    else if (force_sw)
      owner_d = oth;
    else if (p0_req && p1_req)
      owner_d = last_q ? OWN_P0 : OWN_P1;
    else if (p0_req)
      owner_d = OWN_P0;
    else if (p1_req)
      owner_d = OWN_P1;
  end

  // Reset starts with last = port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= OWN_NONE;
      last_q  <= 1'b1;
    end else begin
      owner_q <= owner_d;
      if (owner_d != OWN_NONE)
        last_q <= (owner_d == OWN_P1);
    end
  end

  // Grants come only from the owner register, never from req directly, so
  // an asynchronous reset kills them (and mem_we) immediately.
  assign p0_gnt   = (owner_q == OWN_P0);
  assign p1_gnt   = (owner_q == OWN_P1);
  assign owner    = owner_q;
  assign p0_stall = p0_req & ~p0_gnt;

  assign mem_addr = p0_gnt ? p0_addr : (p1_gnt ? p1_addr : '0);
  assign mem_wd   = p0_gnt ? p0_wd   : (p1_gnt ? p1_wd   : '0);
  assign mem_we   = (p0_gnt & p0_req & p0_we) | (p1_gnt & p1_req & p1_we);

  assign p0_rd = p0_gnt ? mem_rd : '0;
  assign p1_rd = p1_gnt ? mem_rd : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model of ownership and memory contents.
module tb_dmem_arbiter;
  localparam int W  = 32;
  localparam int ML = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         p0_req, p1_req, p0_lock, p1_lock, p0_we, p1_we;
  logic [W-1:0] p0_addr, p1_addr, p0_wd, p1_wd;
  logic         p0_gnt, p1_gnt, p0_stall, mem_we;
  logic [W-1:0] p0_rd, p1_rd, mem_addr, mem_wd, mem_rd;
  logic [1:0]   owner;

  dmem_arbiter #(.WIDTH(W), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p1_req(p1_req), .p0_lock(p0_lock), .p1_lock(p1_lock),
    .p0_we(p0_we), .p1_we(p1_we), .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_wd(p0_wd), .p1_wd(p1_wd), .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rd(p0_rd), .p1_rd(p1_rd), .p0_stall(p0_stall), .owner(owner),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Word-addressed data memory seen by the DUT, plus the model's copy.
  logic [W-1:0] dmem    [0:63];
  logic [W-1:0] ref_mem [0:63];
  assign mem_rd = dmem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[7:2]] <= mem_wd;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  // Behavioural model: who owns the bus (0/1/2), who was granted last (1/2),
  // how many cycles the owner has been kept by its lock, and transfer flags.
  int m_own, m_last, m_cnt;
  bit x0, x1;

  always @(posedge clk or negedge reset) begin
    int nxt, me_req, me_lock, other_req, other;
    bit keep;
    if (!reset) begin
      m_own = 0; m_last = 2; m_cnt = 0; x0 = 0; x1 = 0;
    end else begin
      x0 = (m_own == 1) && p0_req;
      x1 = (m_own == 2) && p1_req;
      if (x0 && p0_we) ref_mem[p0_addr[7:2]] = p0_wd;
      if (x1 && p1_we) ref_mem[p1_addr[7:2]] = p1_wd;
      me_req    = (m_own == 1) ? int'(p0_req)  : (m_own == 2) ? int'(p1_req)  : 0;
      me_lock   = (m_own == 1) ? int'(p0_lock) : (m_own == 2) ? int'(p1_lock) : 0;
      other_req = (m_own == 1) ? int'(p1_req)  : (m_own == 2) ? int'(p0_req)  : 0;
      other     = 3 - m_own;
      keep = (me_req != 0) && (me_lock != 0);
      if (keep && STARVE && other_req != 0 && m_cnt >= ML) begin
        nxt = other; m_cnt = 0;
      end else if (keep) begin
        nxt = m_own;
        m_cnt = (other_req != 0) ? ((m_cnt < 255) ? m_cnt + 1 : 255) : 0;
      end else begin
        m_cnt = 0;
        if (p0_req && p1_req) nxt = (m_last == 1) ? 2 : 1;
        else if (p0_req)      nxt = 1;
        else if (p1_req)      nxt = 2;
        else                  nxt = 0;
      end
      if (nxt != 0) m_last = nxt;
      m_own = nxt;
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic [W-1:0] e_addr, e_wd, e_rd;
    logic e_we;
    if (chk_en) begin
      e_addr = (m_own == 1) ? p0_addr : (m_own == 2) ? p1_addr : '0;
      e_wd   = (m_own == 1) ? p0_wd   : (m_own == 2) ? p1_wd   : '0;
      e_we   = ((m_own == 1) && p0_req && p0_we) || ((m_own == 2) && p1_req && p1_we);
      e_rd   = ref_mem[e_addr[7:2]];
      chk("owner",    {30'd0, owner}, m_own);
      chk("p0_gnt",   p0_gnt, m_own == 1);
      chk("p1_gnt",   p1_gnt, m_own == 2);
      chk("p0_stall", p0_stall, p0_req && m_own != 1);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wd",   mem_wd, e_wd);
      chk("mem_we",   mem_we, e_we);
      chk("p0_rd",    p0_rd, (m_own == 1) ? e_rd : '0);
      chk("p1_rd",    p1_rd, (m_own == 2) ? e_rd : '0);
    end
  end

  task automatic step();   // inputs change 2 time units after the edge
    @(posedge clk); #2;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic idle_inputs();
    p0_req = 0; p1_req = 0; p0_lock = 0; p1_lock = 0; p0_we = 0; p1_we = 0;
    p0_addr = '0; p1_addr = '0; p0_wd = '0; p1_wd = '0;
  endtask

  task automatic do_reset();
    step(); idle_inputs(); reset = 1'b0;
    step(); reset = 1'b1;
  endtask

  initial begin
    int first;
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 64; i++) begin
      dmem[i] = 32'h1000_0000 + i; ref_mem[i] = 32'h1000_0000 + i;
    end
    dmem[16] = 32'h1234; ref_mem[16] = 32'h1234;

    // Reset state, with p0 requesting so the stall must follow req.
    p0_req = 1;
    repeat (2) @(posedge clk);
    at_neg();
    chk("rst_owner", {30'd0, owner}, 0);
    chk("rst_gnt",   {p0_gnt, p1_gnt}, 0);
    chk("rst_we",    mem_we, 0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_rd",    p0_rd | p1_rd, 0);
    chk("rst_stall", p0_stall, 1);
    step(); reset = 1'b1; p0_req = 0; chk_en = 1'b1;

    // Single read by port 0: one stall cycle, then granted with data.
    step(); p0_req = 1; p0_addr = 32'h40;
    at_neg();
    chk("t1_stall_n", p0_stall, 1);
    chk("t1_gnt_n",   p0_gnt, 0);
    step();
    at_neg();
    chk("t1_gnt",   p0_gnt, 1);
    chk("t1_rd",    p0_rd, 32'h1234);
    chk("t1_owner", {30'd0, owner}, 1);
    chk("t1_stall", p0_stall, 0);
    step(); p0_req = 0;
    step();

    // Both ports request from the first cycle: strict alternation.
    do_reset();
    p0_req = 1; p0_addr = 32'h40; p1_req = 1; p1_addr = 32'h80;
    for (int k = 0; k < 6; k++) begin
      step(); at_neg();
      chk("t2_owner", {30'd0, owner}, (k % 2 == 0) ? 1 : 2);
      chk("t2_addr",  mem_addr, (k % 2 == 0) ? 32'h40 : 32'h80);
    end
    step(); idle_inputs();
    step();

    // Port 1 locked write for three cycles while port 0 waits.
    do_reset();
    p1_req = 1; p1_lock = 1; p1_we = 1; p1_addr = 32'h10; p1_wd = 32'hDEAD;
    step(); p0_req = 1; p0_addr = 32'h40;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) p1_lock = 0;
      at_neg();
      chk("t3_owner", {30'd0, owner}, 2);
      chk("t3_stall", p0_stall, 1);
      if (k == 1) chk("t3_mem", dmem[4], 32'hDEAD);
      step();
    end
    p1_req = 0;
    at_neg();
    chk("t3_p0_gnt", p0_gnt, 1);
    step(); idle_inputs();
    step();

    // Port 1 locked forever, port 0 waiting.
    do_reset();
    p1_req = 1; p1_lock = 1; p1_addr = 32'h80;
    step(); p0_req = 1; p0_addr = 32'h40;
    first = 99;
    for (int k = 0; k < 20; k++) begin
      at_neg();
      if (p0_gnt && first == 99) first = k;
      step();
    end
    chk("t4_p0_first_gnt", first, STARVE ? ML + 1 : 99);
    idle_inputs();
    step();

    // Reset in the middle of a port 0 write grant.
    do_reset();
    dmem[8] = 32'h5555; ref_mem[8] = 32'h5555;
    p0_req = 1; p0_we = 1; p0_addr = 32'h20; p0_wd = 32'hBEEF;
    step();
    at_neg();
    chk("t5_pre_we", mem_we, 1);
    reset = 1'b0; #1;
    chk("t5_we",    mem_we, 0);
    chk("t5_gnt",   p0_gnt, 0);
    chk("t5_stall", p0_stall, 1);
    step(); p0_req = 0; p0_we = 0; reset = 1'b1;
    at_neg();
    chk("t5_mem",   dmem[8], 32'h5555);
    chk("t5_owner", {30'd0, owner}, 0);

    // Randomized traffic; each port keeps its fields until it transfers.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      step();
      if (!p0_req || x0) begin
        p0_req = ($urandom_range(0, 3) != 0); p0_lock = ($urandom_range(0, 3) == 0);
        p0_we = $urandom_range(0, 1) == 1; p0_addr = $urandom_range(0, 63) << 2; p0_wd = $urandom;
      end
      if (!p1_req || x1) begin
        p1_req = ($urandom_range(0, 3) != 0); p1_lock = ($urandom_range(0, 3) == 0);
        p1_we = $urandom_range(0, 1) == 1; p1_addr = $urandom_range(0, 63) << 2; p1_wd = $urandom;
      end
    end
    step(); idle_inputs();
    step(); step();
    for (int i = 0; i < 64; i++) chk("final_mem", dmem[i], ref_mem[i]);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-cycle core's data memory between the `mips` core (port 0) and a second bus master (port 1, e.g. the program/data loader or a debug port). It sits between the masters and `dmem`. It keeps a registered owner, applies round-robin fairness with optional bus locking, and drives the one `dmem` read/write port. Port 0 gets a stall indication so the core can freeze its PC while it waits.

## Interface
- `WIDTH`, 32, data and address width.
- `MAX_LOCK`, 8, maximum consecutive locked cycles while the other port waits; valid range 1..255. Used only with `DMEM_ARB_STARVE_EN`.

- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `p0_req`, `p1_req`  input  1  access request; requester holds it and its fields stable until a transfer occurs.
- `p0_lock`, `p1_lock`  input  1  keep ownership after the current transfer.
- `p0_we`, `p1_we`  input  1  1 = write, 0 = read.
- `p0_addr`, `p1_addr`  input  WIDTH  byte address.
- `p0_wd`, `p1_wd`  input  WIDTH  write data.
- `p0_gnt`, `p1_gnt`  output  1  port owns memory this cycle.
- `p0_rd`, `p1_rd`  output  WIDTH  read data; equals `mem_rd` when the port is granted, otherwise 0.
- `p0_stall`  output  1  `p0_req & ~p0_gnt`.
- `owner`  output  2  current owner: 0 = none, 1 = port 0, 2 = port 1.
- `mem_addr`  output  WIDTH  to `dmem.addr`.
- `mem_wd`  output  WIDTH  to `dmem.wd`.
- `mem_we`  output  1  to `dmem.we`.
- `mem_rd`  input  WIDTH  from `dmem.rd` (combinational read).

## Operation
- State:
  - `owner` register (NONE/P0/P1).
  - `last` pointer, the last port granted by arbitration.
  - `lock_cnt` counter, 8 bits.
- Grant signals: `pX_gnt = (owner == PX)`. A transfer occurs in any cycle where `pX_req & pX_gnt`.
- Memory port mux:
  - `mem_addr` and `mem_wd` come from the owner's inputs; both are 0 when `owner` is NONE.
  - `mem_we = gnt & req & we` of the owner. A granted port that has dropped `req` performs no access.
- Next-owner rule, evaluated every edge, in priority order:
  1. Owner X has `req` and `lock` high, and no forced switch applies → keep X.
  2. Exactly one port requests → that port.
  3. Both ports request → the port that is not `last`.
  4. No port requests → NONE.
- `last` updates whenever the owner changes to P0 or P1 through rules 2 or 3.
- Without locking, two continuously requesting ports alternate owner every cycle.
- Lock counter:
  - Increments while rule 1 holds and the other port is requesting.
  - Clears on any owner change, or when the other port is not requesting.
  - Saturates at 255.
- Reset mid-operation: `owner` goes to NONE immediately. `mem_we` drops combinationally, so the in-flight write is not committed.

## Timing
- Reset values:
  - `owner` = NONE, `last` = P1 (port 0 wins the first tie), `lock_cnt` = 0.
  - All `gnt` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wd` = 0, `p0_rd` = `p1_rd` = 0, `p0_stall` = `p0_req`.
- Grant latency: a request raised in cycle N with the arbiter free is granted in cycle N+1.
- Reads: data is valid in `pX_rd` during the grant cycle.
- Writes: commit at the rising edge that ends the grant cycle.
- An uncontended port holding `req` high keeps its grant every cycle, giving one transfer per cycle.
- Simultaneous first requests from both ports after reset: P0 is granted at N+1, P1 at N+2.
- Owner change and `last` update occur on the same edge. The new `pX_gnt` appears after that edge, never combinationally from `req`.

## Configuration
- `DMEM_ARB_STARVE_EN` defined: when `lock_cnt` reaches `MAX_LOCK` while the other port requests, the next edge forces ownership to the other port (overriding rule 1) and clears `lock_cnt`.
- Not defined: `lock` is honoured indefinitely, and `lock_cnt` logic is removed.

## Test plan
- Reset released, then `p0_req=1`, `p0_we=0`, `p0_addr=0x40`, with `dmem[0x40]=0x1234`: `p0_gnt=1` next cycle, `p0_rd=0x1234`, `owner=1`, `p0_stall` high for exactly one cycle.
- Both ports request from cycle 0, no lock: grants alternate P0, P1, P0, …; `mem_addr` alternates between the two addresses.
- P1 writes `0xDEAD` to `0x10` with `p1_lock=1` for 3 cycles while P0 requests: P1 holds `owner=2` for 3 cycles. `dmem[0x10]=0xDEAD` after the first grant edge. `p0_stall=1` throughout, then P0 is granted.
- With `DMEM_ARB_STARVE_EN`, `MAX_LOCK=4`, P1 locked permanently and P0 requesting: P0 is granted after 4 locked cycles. Without the macro, P0 is never granted.
- `reset` asserted during a P0 write grant: `mem_we` and `p0_gnt` go to 0 immediately, memory is unchanged, and after release `owner=0`.
